operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//   Operand-fetch stage feeding the shift-left execute unit. It holds an 8-entry x 8-bit register
//   file, reads the source register and launches {ReadData, Shamt, DestReg} through a
//   valid/ready output register. It tracks in-flight destination writes in a pending scoreboard
//   and stalls read-after-write hazards until writeback. Writeback arrives from downstream on the
//   RegWrite port.
// PARAMETERS
//   DATA_W   8  register/operand width
//   ADDR_W   3  register address width (NREGS = 2**ADDR_W = 8)
//   SHAMT_W  3  shift-amount width
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   InValid    in   1        instruction present
//   InReady    out  1        stage accepts instruction this cycle
//   SrcReg     in   ADDR_W   source register to read
//   ShamtIn    in   SHAMT_W  shift amount (passed through)
//   DstReg     in   ADDR_W   destination register of instruction
//   DstWrEn    in   1        instruction will write DstReg
//   RegWrite   in   1        writeback strobe
//   WbAddr     in   ADDR_W   writeback address
//   WbData     in   DATA_W   writeback data
//   OutValid   out  1        operands valid to execute stage
//   OutReady   in   1        execute stage accepts
//   ReadData   out  DATA_W   source operand
//   Shamt      out  SHAMT_W  registered shift amount
//   DestReg    out  ADDR_W   registered destination
//   DestWrEn   out  1        registered write enable
// BEHAVIOUR
//   - Reset (async, rst_n=0): all 8 registers=0, pending bitmap=0, OutValid=0,
//     ReadData/Shamt/DestReg=0, DestWrEn=0. Reset asserted mid-transfer drops the output
//     instruction and clears the scoreboard.
//   - Writeback: RegWrite=1 writes WbData to regs[WbAddr] at the clock edge and clears
//     pending[WbAddr].
//   - Read bypass: if RegWrite && WbAddr==SrcReg in the same cycle, the operand is WbData.
//     Otherwise it is regs[SrcReg].
//   - Hazard: hazard = pending[SrcReg] && !(RegWrite && WbAddr==SrcReg).
//   - Output slot free: slot_free = !OutValid || OutReady.
//   - Handshake: InReady = slot_free && !hazard (combinational). Accept = InValid && InReady.
//   - Latency: 1 cycle. On accept, the output register loads {operand, ShamtIn, DstReg, DstWrEn}
//     and OutValid=1 next cycle.
//   - No accept but OutReady && OutValid: OutValid->0 next cycle.
//   - Output hold: while OutValid && !OutReady, all outputs hold stable.
//   - Scoreboard set: on accept with DstWrEn=1, pending[DstReg] <= 1.
//   - Set/clear same cycle, same address: set wins (the new writer supersedes).
//   - Self-dependency: SrcReg==DstReg is legal. The read sees the old value, then the entry is
//     marked pending.
//   - Full throughput: 1 instr/cycle when there is no hazard and OutReady=1.
//   - Writeback to a non-pending address is legal; the register is updated.
// STRUCTURE
//   - Shared package: DATA_W/ADDR_W/SHAMT_W constants and the fetch-to-execute bundle
//     {ReadData, Shamt, DestReg, DestWrEn} as a struct/typedef.
//   - One sub-module: regfile_1r1w_bypass (8x8 storage, async read, sync write, write-to-read
//     bypass).
//   - Scoreboard, handshake and output register stay in the top module.
// TESTING
//   1. Reset: rst_n=0 mid-stream with OutValid=1 -> OutValid=0 immediately; every register
//      reads 0 afterwards.
//   2. Writeback then read: RegWrite r3=0xA5, then issue SrcReg=3 ShamtIn=2 -> next cycle
//      ReadData=0xA5, Shamt=2, OutValid=1.
//   3. Bypass: same cycle RegWrite r5=0x3C and issue SrcReg=5 -> InReady=1, ReadData=0x3C
//      next cycle.
//   4. RAW stall: issue Dst=r2 WrEn=1, then Src=r2 -> InReady=0 until RegWrite r2=0x81;
//      in that cycle accepted with ReadData=0x81.
//   5. Backpressure: OutReady=0 for 4 cycles with InValid=1 -> outputs stable,
//      InReady=0, no instruction lost or duplicated.
//   6. Set/clear collision: RegWrite r4 while accepting Dst=r4 WrEn=1 -> pending[4] stays 1,
//      next Src=r4 stalls.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// rtl/operand_fetch_stage_pkg.sv - shared widths and fetch-to-execute bundle
package operand_fetch_stage_pkg;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 3;
  localparam int SHAMT_W = 3;
  localparam int NREGS   = 1 << ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0]  read_data;
    logic [SHAMT_W-1:0] shamt;
    logic [ADDR_W-1:0]  dest_reg;
    logic               dest_wr_en;
  } fx_bundle_t;
endpackage

// File: rtl/regfile_1r1w_bypass.sv
// rtl/regfile_1r1w_bypass.sv - 8x8 register file, async read, sync write, write-to-read bypass
module regfile_1r1w_bypass
  import operand_fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Same-cycle writeback is forwarded so a reader never sees the stale value.
  assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : regs_q[rd_addr];
endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch with RAW scoreboard and valid/ready output register
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [ADDR_W-1:0]  SrcReg,
  input  logic [SHAMT_W-1:0] ShamtIn,
  input  logic [ADDR_W-1:0]  DstReg,
  input  logic               DstWrEn,
  input  logic               RegWrite,
  input  logic [ADDR_W-1:0]  WbAddr,
  input  logic [DATA_W-1:0]  WbData,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [DATA_W-1:0]  ReadData,
  output logic [SHAMT_W-1:0] Shamt,
  output logic [ADDR_W-1:0]  DestReg,
  output logic               DestWrEn
);
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              out_valid_q, out_valid_d;
  fx_bundle_t        out_q, out_d;
  logic [DATA_W-1:0] operand;
  logic              wb_hits_src, hazard, slot_free, accept;

  regfile_1r1w_bypass u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (RegWrite),
    .wr_addr (WbAddr),
    .wr_data (WbData),
    .rd_addr (SrcReg),
    .rd_data (operand)
  );

  always_comb begin
    wb_hits_src = RegWrite && (WbAddr == SrcReg);
    hazard      = pending_q[SrcReg] && !wb_hits_src;
    slot_free   = !out_valid_q || OutReady;
    InReady     = slot_free && !hazard;
    accept      = InValid && InReady;
  end

  always_comb begin
    pending_d = pending_q;
    if (RegWrite) pending_d[WbAddr] = 1'b0;
    // Applied after the clear so a new writer supersedes a retiring one.
    if (accept && DstWrEn) pending_d[DstReg] = 1'b1;
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d.read_data  = operand;
      out_d.shamt      = ShamtIn;
      out_d.dest_reg   = DstReg;
      out_d.dest_wr_en = DstWrEn;
      out_valid_d      = 1'b1;
    end else if (OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign OutValid = out_valid_q;
  assign ReadData = out_q.read_data;
  assign Shamt    = out_q.shamt;
  assign DestReg  = out_q.dest_reg;
  assign DestWrEn = out_q.dest_wr_en;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed table-driven bench for operand_fetch_stage
module tb_operand_fetch_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       InValid, InReady;
  logic [2:0] SrcReg, ShamtIn, DstReg;
  logic       DstWrEn, RegWrite;
  logic [2:0] WbAddr;
  logic [7:0] WbData;
  logic       OutValid, OutReady;
  logic [7:0] ReadData;
  logic [2:0] Shamt, DestReg;
  logic       DestWrEn;

  int checks = 0;
  int errors = 0;

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .SrcReg(SrcReg), .ShamtIn(ShamtIn), .DstReg(DstReg), .DstWrEn(DstWrEn),
    .RegWrite(RegWrite), .WbAddr(WbAddr), .WbData(WbData),
    .OutValid(OutValid), .OutReady(OutReady), .ReadData(ReadData),
    .Shamt(Shamt), .DestReg(DestReg), .DestWrEn(DestWrEn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       in_valid;
    logic [2:0] src, sh, dst;
    logic       wren;
    logic       wb;
    logic [2:0] wba;
    logic [7:0] wbd;
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic [7:0] exp_rd;
    logic [2:0] exp_sh, exp_dst;
    logic       exp_wren;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic [2:0] src, logic [2:0] sh, logic [2:0] dst,
                              logic wren, logic wb, logic [2:0] wba, logic [7:0] wbd,
                              logic eir, logic eov, logic [7:0] erd, logic [2:0] esh,
                              logic [2:0] edst, logic ewr);
    vec_t v;
    v.in_valid = iv; v.src = src; v.sh = sh; v.dst = dst; v.wren = wren;
    v.wb = wb; v.wba = wba; v.wbd = wbd;
    v.exp_in_ready = eir; v.exp_out_valid = eov; v.exp_rd = erd;
    v.exp_sh = esh; v.exp_dst = edst; v.exp_wren = ewr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic iv, logic [2:0] src, logic [2:0] sh, logic [2:0] dst, logic wren,
                       logic wb, logic [2:0] wba, logic [7:0] wbd, logic ordy);
    InValid = iv; SrcReg = src; ShamtIn = sh; DstReg = dst; DstWrEn = wren;
    RegWrite = wb; WbAddr = wba; WbData = wbd; OutReady = ordy;
  endtask

  task automatic chk_out(string tag, logic [7:0] rd, logic [2:0] sh, logic [2:0] dst, logic wr);
    chk({tag, ".OutValid"}, {31'd0, OutValid}, 32'd1);
    chk({tag, ".ReadData"}, {24'd0, ReadData}, {24'd0, rd});
    chk({tag, ".Shamt"},    {29'd0, Shamt},    {29'd0, sh});
    chk({tag, ".DestReg"},  {29'd0, DestReg},  {29'd0, dst});
    chk({tag, ".DestWrEn"}, {31'd0, DestWrEn}, {31'd0, wr});
  endtask

  initial begin
    //            iv src sh dst wr  wb wba wbd      eir eov erd     esh edst ewr
    vecs[0]  = mk(0, 0, 0, 0, 0,  1, 3, 8'hA5,   1, 0, 8'h00, 0, 0, 0);
    vecs[1]  = mk(1, 3, 2, 1, 0,  0, 0, 8'h00,   1, 1, 8'hA5, 2, 1, 0);
    vecs[2]  = mk(1, 5, 7, 6, 0,  1, 5, 8'h3C,   1, 1, 8'h3C, 7, 6, 0);
    vecs[3]  = mk(1, 0, 1, 2, 1,  0, 0, 8'h00,   1, 1, 8'h00, 1, 2, 1);
    vecs[4]  = mk(1, 2, 3, 7, 0,  0, 0, 8'h00,   0, 0, 8'h00, 0, 0, 0);
    vecs[5]  = mk(1, 2, 3, 7, 0,  0, 0, 8'h00,   0, 0, 8'h00, 0, 0, 0);
    vecs[6]  = mk(1, 2, 3, 7, 0,  1, 2, 8'h81,   1, 1, 8'h81, 3, 7, 0);
    vecs[7]  = mk(1, 2, 0, 0, 0,  0, 0, 8'h00,   1, 1, 8'h81, 0, 0, 0);
    vecs[8]  = mk(1, 1, 4, 4, 1,  1, 4, 8'h11,   1, 1, 8'h00, 4, 4, 1);
    vecs[9]  = mk(1, 4, 0, 0, 0,  0, 0, 8'h00,   0, 0, 8'h00, 0, 0, 0);
    vecs[10] = mk(1, 4, 0, 0, 0,  1, 4, 8'h22,   1, 1, 8'h22, 0, 0, 0);
    vecs[11] = mk(1, 3, 5, 3, 1,  0, 0, 8'h00,   1, 1, 8'hA5, 5, 3, 1);
    vecs[12] = mk(1, 3, 0, 0, 0,  0, 0, 8'h00,   0, 0, 8'h00, 0, 0, 0);
    vecs[13] = mk(0, 3, 0, 0, 0,  1, 3, 8'h5A,   1, 0, 8'h00, 0, 0, 0);
    vecs[14] = mk(1, 3, 6, 5, 0,  0, 0, 8'h00,   1, 1, 8'h5A, 6, 5, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.OutValid", {31'd0, OutValid}, 32'd0);
    chk("reset.ReadData", {24'd0, ReadData}, 32'd0);
    chk("reset.DestWrEn", {31'd0, DestWrEn}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].in_valid, vecs[i].src, vecs[i].sh, vecs[i].dst, vecs[i].wren,
            vecs[i].wb, vecs[i].wba, vecs[i].wbd, 1'b1);
      #1;
      chk($sformatf("v%0d.InReady", i), {31'd0, InReady}, {31'd0, vecs[i].exp_in_ready});
      @(posedge clk);
      #1;
      if (vecs[i].exp_out_valid)
        chk_out($sformatf("v%0d", i), vecs[i].exp_rd, vecs[i].exp_sh, vecs[i].exp_dst,
                vecs[i].exp_wren);
      else
        chk($sformatf("v%0d.OutValid", i), {31'd0, OutValid}, 32'd0);
    end

    // Backpressure: output from v14 must hold while a new instruction waits.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1, 1, 2, 6, 0, 0, 0, 8'h00, 0);
      #1;
      chk($sformatf("bp%0d.InReady", c), {31'd0, InReady}, 32'd0);
      @(posedge clk);
      #1;
      chk_out($sformatf("bp%0d", c), 8'h5A, 6, 5, 0);
    end
    @(negedge clk);
    drive(1, 1, 2, 6, 0, 0, 0, 8'h00, 1);
    #1;
    chk("bp_release.InReady", {31'd0, InReady}, 32'd1);
    @(posedge clk);
    #1;
    chk_out("bp_release", 8'h00, 2, 6, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    @(posedge clk);
    #1;
    chk("bp_drain.OutValid", {31'd0, OutValid}, 32'd0);

    // Mid-stream reset: held output with a pending write to r7 outstanding.
    @(negedge clk);
    drive(1, 0, 1, 7, 1, 0, 0, 8'h00, 0);
    @(posedge clk);
    #1;
    chk("pre_rst.OutValid", {31'd0, OutValid}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.OutValid", {31'd0, OutValid}, 32'd0);
    chk("midrst.DestReg",  {29'd0, DestReg},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      drive(1, r[2:0], 0, 0, 0, 0, 0, 8'h00, 1);
      #1;
      chk($sformatf("postrst_r%0d.InReady", r), {31'd0, InReady}, 32'd1);
      @(posedge clk);
      #1;
      chk_out($sformatf("postrst_r%0d", r), 8'h00, 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
